oam_dma_arbiter: RTL and testbench
==================================

OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  system clock (4 MHz T-cycle clock).
REQ-002 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have CPU-side ports, all from/to the CPU:
- cpu_mem_addr  input  16  CPU address.
- cpu_mem_enable  input  1  CPU access request.
- cpu_mem_write  input  1  CPU write request.
- cpu_mem_data_out  input  8  CPU write data.
- cpu_mem_data_in  output  8  read data returned to the CPU.
REQ-004 SHALL have system-bus ports:
- bus_addr  output  16  bus address.
- bus_enable  output  1  bus access.
- bus_write  output  1  bus write.
- bus_data_out  output  8  bus write data.
- bus_data_in  input  8  bus read data.
REQ-005 SHALL have OAM ports:
- oam_addr  output  8  OAM byte index.
- oam_write  output  1  OAM write strobe.
- oam_data  output  8  OAM write data.
REQ-006 SHALL have port: dma_active  output  1  transfer in progress (START or XFER).

Function
REQ-007 SHALL keep a free-running 2-bit t_cycle counter: it increments every clk, and one M-cycle is t_cycle 0..3; all state updates occur on the clk edge where t_cycle==3.
REQ-008 SHALL decode a DMA trigger as cpu_mem_enable && cpu_mem_write && cpu_mem_addr==16'hFF46, sampled at t_cycle==3; this latches cpu_mem_data_out into the 8-bit page register.
REQ-009 SHALL NOT forward the FF46 write to the bus; a CPU read of FF46 SHALL return the page register, with bus_enable=0.
REQ-010 SHALL implement a state machine with states IDLE, START and XFER:
- IDLE -> START on trigger.
- START -> XFER after one M-cycle, with index=0.
- XFER -> IDLE after the M-cycle in which index 159 is transferred.
REQ-011 SHALL drive the XFER source address as {page,index} for page<=8'hDF, and {page-8'h20,index} for page>=8'hE0 (echo-RAM mapping).
REQ-012 SHALL, in a non-stalled XFER M-cycle:
- drive bus_enable=1, bus_write=0 and bus_addr=source for all four T-cycles;
- at t_cycle==3, drive oam_write=1, oam_addr=index and oam_data=bus_data_in, then increment index.
REQ-013 SHALL stall an XFER M-cycle when the CPU has a granted access (REQ-014) that M-cycle; a stall means the CPU owns the bus, no OAM write occurs and index is held.
REQ-014 SHALL grant the CPU the bus when dma_active=0, or when cpu_mem_addr>=16'hFF80 (HRAM/IE); a granted access passes address, enable, write, data and read data through unchanged.
REQ-015 SHALL treat a trigger during START or XFER as a restart: relatch the page, enter START, reset index to 0, and keep dma_active=1.
REQ-016 SHALL make dma_active rise on the edge after the trigger M-cycle and fall on the edge completing index 159; a transfer takes exactly 161 M-cycles from trigger with no stalls.
REQ-017 SHALL never assert oam_write outside XFER or at t_cycle!=3.

Reset
REQ-018 SHALL, while reset_n=0, asynchronously force:
- t_cycle=0, state=IDLE, page=8'h00, index=0;
- dma_active=0, oam_write=0;
- bus_enable=0, bus_write=0, cpu_mem_data_in=8'hFF.
REQ-019 SHALL abort any START or XFER on reset assertion mid-transfer with no further OAM writes; after release the block is in IDLE.

Configuration
REQ-020 SHALL honour macro OAM_DMA_CPU_BLOCK_EN, as follows.
- Defined: while dma_active=1, a CPU access below FF80 (other than FF46) is not granted. Reads return 8'hFF, writes are dropped, and the DMA is not stalled.
- Undefined: such an access is granted and stalls the DMA, exactly as for HRAM accesses in REQ-013/REQ-014.

Verification
REQ-021 Write 8'hC0 to FF46, with bus memory C000+i = i ^ 8'h5A -> dma_active high 161 M-cycles; 160 oam_write pulses with oam_data[i] = i^8'h5A; final oam_addr=159.
REQ-022 Write 8'hE1 to FF46 -> bus_addr sequence C100..C19F.
REQ-023 CPU reads FF80 on every 10th M-cycle during DMA -> reads return correct HRAM data; total duration 161 plus the number of stalls; no skipped or duplicated indices.
REQ-024 With OAM_DMA_CPU_BLOCK_EN defined, CPU reads C000 during DMA -> returns 8'hFF and the DMA is not stalled; without the macro -> returns memory data and the DMA is stalled by one M-cycle.
REQ-025 Write 8'h80 at index 50, then 8'h90 -> transfer restarts with an index 0 read at 9000; dma_active never drops.
REQ-026 Assert reset_n=0 at index 77 -> dma_active and oam_write go to 0 immediately; no OAM writes occur after release.

Source files
------------

// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine and CPU/DMA bus arbiter; copies 160 bytes from {page,00..9F} into OAM.
// Optional build macro OAM_DMA_CPU_BLOCK_EN: block CPU accesses below FF80 while the DMA runs.
module oam_dma_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_mem_addr,
  input  logic        cpu_mem_enable,
  input  logic        cpu_mem_write,
  input  logic [7:0]  cpu_mem_data_out,
  output logic [7:0]  cpu_mem_data_in,
  output logic [15:0] bus_addr,
  output logic        bus_enable,
  output logic        bus_write,
  output logic [7:0]  bus_data_out,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  oam_addr,
  output logic        oam_write,
  output logic [7:0]  oam_data,
  output logic        dma_active
);

`ifdef OAM_DMA_CPU_BLOCK_EN
  localparam bit CPU_BLOCK = 1'b1;
`else
  localparam bit CPU_BLOCK = 1'b0;
`endif

  localparam logic [15:0] DMA_REG   = 16'hFF46;
  localparam logic [15:0] HRAM_BASE = 16'hFF80;
  localparam logic [7:0]  LAST_IDX  = 8'd159;

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  state_t      state, state_nxt;
  logic [1:0]  t_cycle;
  logic [7:0]  page, page_nxt;
  logic [7:0]  index, index_nxt;
  logic        is_reg, trig, hram, cpu_grant, stall, m_end;
  logic [7:0]  src_page;
  logic [15:0] src_addr;

  assign m_end      = (t_cycle == 2'd3);
  assign dma_active = (state != IDLE);
  assign is_reg     = cpu_mem_enable && (cpu_mem_addr == DMA_REG);
  assign trig       = is_reg && cpu_mem_write;
  assign hram       = (cpu_mem_addr >= HRAM_BASE);
  // FF46 is served locally and never reaches the bus
  assign cpu_grant  = cpu_mem_enable && !is_reg && (!dma_active || hram || !CPU_BLOCK);
  assign stall      = (state == XFER) && cpu_grant;
  // E0..FF pages alias down onto work RAM, as the echo region does
  assign src_page   = (page >= 8'hE0) ? (page - 8'h20) : page;
  assign src_addr   = {src_page, index};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_cycle <= 2'd0;
      state   <= IDLE;
      page    <= 8'h00;
      index   <= 8'd0;
    end else begin
      t_cycle <= t_cycle + 2'd1;
      state   <= state_nxt;
      page    <= page_nxt;
      index   <= index_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    page_nxt  = page;
    index_nxt = index;
    if (m_end) begin
      if (trig) begin
        // a trigger in any state (re)starts from index 0
        page_nxt  = cpu_mem_data_out;
        state_nxt = START;
        index_nxt = 8'd0;
      end else begin
        case (state)
          START: begin
            state_nxt = XFER;
            index_nxt = 8'd0;
          end
          XFER: if (!stall) begin
            index_nxt = index + 8'd1;
            if (index == LAST_IDX) state_nxt = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus_addr        = 16'h0000;
    bus_enable      = 1'b0;
    bus_write       = 1'b0;
    bus_data_out    = 8'h00;
    cpu_mem_data_in = 8'hFF;
    if (reset_n) begin
      if (cpu_grant) begin
        bus_addr        = cpu_mem_addr;
        bus_enable      = 1'b1;
        bus_write       = cpu_mem_write;
        bus_data_out    = cpu_mem_data_out;
        cpu_mem_data_in = bus_data_in;
      end else if (state == XFER) begin
        bus_addr   = src_addr;
        bus_enable = 1'b1;
      end
      if (is_reg) cpu_mem_data_in = page;
    end
  end

  assign oam_write = reset_n && (state == XFER) && m_end && !stall;
  assign oam_addr  = index;
  assign oam_data  = bus_data_in;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: bus memory model, OAM write logger, step-by-step checks.
module tb_oam_dma_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_mem_addr = 16'h0;
  logic        cpu_mem_enable = 1'b0;
  logic        cpu_mem_write = 1'b0;
  logic [7:0]  cpu_mem_data_out = 8'h0;
  logic [7:0]  cpu_mem_data_in;
  logic [15:0] bus_addr;
  logic        bus_enable, bus_write;
  logic [7:0]  bus_data_out, bus_data_in;
  logic [7:0]  oam_addr, oam_data;
  logic        oam_write, dma_active;

  logic [7:0]  mem [0:65535];
  logic [7:0]  log_addr [0:2047];
  logic [7:0]  log_data [0:2047];
  logic [15:0] log_bus  [0:2047];
  int          wr_cnt = 0, act_cnt = 0, bad_phase = 0;
  logic [1:0]  tc;
  int          errors = 0, checks = 0;
  logic [7:0]  rd;
  logic        rd_be;

  always #5 clk = ~clk;

  assign bus_data_in = mem[bus_addr];

  oam_dma_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_enable(cpu_mem_enable),
    .cpu_mem_write(cpu_mem_write), .cpu_mem_data_out(cpu_mem_data_out),
    .cpu_mem_data_in(cpu_mem_data_in),
    .bus_addr(bus_addr), .bus_enable(bus_enable), .bus_write(bus_write),
    .bus_data_out(bus_data_out), .bus_data_in(bus_data_in),
    .oam_addr(oam_addr), .oam_write(oam_write), .oam_data(oam_data),
    .dma_active(dma_active)
  );

  // bench-side T-cycle phase, used only to place samples
  always @(posedge clk or negedge reset_n)
    if (!reset_n) tc <= 2'd0;
    else          tc <= tc + 2'd1;

  always @(negedge clk) begin
    if (oam_write && wr_cnt < 2048) begin
      log_addr[wr_cnt] <= oam_addr;
      log_data[wr_cnt] <= oam_data;
      log_bus[wr_cnt]  <= bus_addr;
      wr_cnt           <= wr_cnt + 1;
    end
    if (oam_write && (tc != 2'd3 || !dma_active)) bad_phase <= bad_phase + 1;
    if (tc == 2'd3 && dma_active) act_cnt <= act_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one M-cycle with the CPU request held; read data sampled in T3
  task automatic mc(input logic en, input logic wr, input logic [15:0] a, input logic [7:0] d);
    cpu_mem_enable = en; cpu_mem_write = wr; cpu_mem_addr = a; cpu_mem_data_out = d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rd = cpu_mem_data_in;
    rd_be = bus_enable;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) mc(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  initial begin
    int b, b2, a0, bad, hbad, drop, n, snap;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[16'hFF80] = 8'h3C;

    // reset with a CPU request pending: bus must stay quiet
    cpu_mem_enable = 1'b1; cpu_mem_addr = 16'hC000;
    #12;
    chk("rst_dma_active", 32'(dma_active), 32'd0);
    chk("rst_oam_write", 32'(oam_write), 32'd0);
    chk("rst_bus_enable", 32'(bus_enable), 32'd0);
    chk("rst_bus_write", 32'(bus_write), 32'd0);
    chk("rst_cpu_data_in", 32'(cpu_mem_data_in), 32'hFF);
    @(negedge clk);
    reset_n = 1'b1;
    cpu_mem_enable = 1'b0;

    // basic transfer from C000
    b = wr_cnt; a0 = act_cnt;
    mc(1'b1, 1'b1, 16'hFF46, 8'hC0);
    mc(1'b1, 1'b0, 16'hFF46, 8'h00);
    chk("ff46_read", 32'(rd), 32'hC0);
    chk("ff46_read_bus_en", 32'(rd_be), 32'd0);
    idle(170);
    chk("c0_active_mcycles", 32'(act_cnt - a0), 32'd161);
    chk("c0_writes", 32'(wr_cnt - b), 32'd160);
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (log_addr[b+i] !== 8'(i) || log_data[b+i] !== (8'(i) ^ 8'h5A)) bad++;
    chk("c0_oam_contents", 32'(bad), 32'd0);
    chk("c0_final_oam_addr", 32'(log_addr[b+159]), 32'd159);
    chk("c0_first_src", 32'(log_bus[b]), 32'hC000);
    chk("c0_last_src", 32'(log_bus[b+159]), 32'hC09F);
    chk("c0_done_inactive", 32'(dma_active), 32'd0);

    // echo page E1 maps onto C1xx
    b = wr_cnt; a0 = act_cnt;
    mc(1'b1, 1'b1, 16'hFF46, 8'hE1);
    idle(170);
    chk("e1_writes", 32'(wr_cnt - b), 32'd160);
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (log_bus[b+i] !== (16'hC100 + 16'(i))) bad++;
    chk("e1_src_sequence", 32'(bad), 32'd0);
    chk("e1_active_mcycles", 32'(act_cnt - a0), 32'd161);

    // HRAM read every 10th M-cycle: 17 of them land in XFER
    b = wr_cnt; a0 = act_cnt; hbad = 0;
    mc(1'b1, 1'b1, 16'hFF46, 8'hC0);
    for (int m = 1; m <= 200; m++) begin
      if (m % 10 == 0) begin
        mc(1'b1, 1'b0, 16'hFF80, 8'h00);
        if (rd !== 8'h3C) hbad++;
      end else idle(1);
    end
    chk("hram_read_data", 32'(hbad), 32'd0);
    chk("hram_active_mcycles", 32'(act_cnt - a0), 32'd178);
    chk("hram_writes", 32'(wr_cnt - b), 32'd160);
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (log_addr[b+i] !== 8'(i) || log_data[b+i] !== (8'(i) ^ 8'h5A)) bad++;
    chk("hram_index_sequence", 32'(bad), 32'd0);

    // work-RAM read during XFER
    b = wr_cnt; a0 = act_cnt;
    mc(1'b1, 1'b1, 16'hFF46, 8'hC0);
    idle(19);
    mc(1'b1, 1'b0, 16'hC000, 8'h00);
`ifdef OAM_DMA_CPU_BLOCK_EN
    chk("wram_read_blocked", 32'(rd), 32'hFF);
    idle(170);
    chk("wram_active_mcycles", 32'(act_cnt - a0), 32'd161);
`else
    chk("wram_read_data", 32'(rd), 32'h5A);
    idle(170);
    chk("wram_active_mcycles", 32'(act_cnt - a0), 32'd162);
`endif
    chk("wram_writes", 32'(wr_cnt - b), 32'd160);

    // restart from page 90 at index 50
    b = wr_cnt; drop = 0; n = 0;
    mc(1'b1, 1'b1, 16'hFF46, 8'h80);
    while (wr_cnt - b < 50 && n < 200) begin
      if (!dma_active) drop++;
      idle(1); n++;
    end
    chk("restart_reach_50", 32'(n < 200), 32'd1);
    mc(1'b1, 1'b1, 16'hFF46, 8'h90);
    b2 = wr_cnt; n = 0;
    while (wr_cnt - b2 < 160 && n < 300) begin
      if (!dma_active) drop++;
      idle(1); n++;
    end
    chk("restart_no_drop", 32'(drop), 32'd0);
    chk("restart_first_idx", 32'(log_addr[b2]), 32'd0);
    chk("restart_first_src", 32'(log_bus[b2]), 32'h9000);
    chk("restart_last_src", 32'(log_bus[b2+159]), 32'h909F);
    chk("restart_writes", 32'(wr_cnt - b2), 32'd160);

    // reset mid-transfer at index 77
    b = wr_cnt; n = 0;
    mc(1'b1, 1'b1, 16'hFF46, 8'hC0);
    while (wr_cnt - b < 77 && n < 200) begin idle(1); n++; end
    cpu_mem_enable = 1'b0; cpu_mem_write = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_pre_oam_write", 32'(oam_write), 32'd1);
    chk("abort_pre_oam_addr", 32'(oam_addr), 32'd77);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_dma_active", 32'(dma_active), 32'd0);
    chk("abort_oam_write", 32'(oam_write), 32'd0);
    repeat (8) @(posedge clk);
    snap = wr_cnt;
    @(negedge clk);
    reset_n = 1'b1;
    idle(200);
    chk("abort_no_more_writes", 32'(wr_cnt - snap), 32'd0);
    chk("abort_idle", 32'(dma_active), 32'd0);
    chk("oam_write_phase", 32'(bad_phase), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
